// File: rtl/demux_strobe_sequencer_if.sv
// Requester / demux / acknowledge bundle for demux_strobe_sequencer.
// master drives requests and acks; slave is the sequencer.
interface demux_strobe_sequencer_if;
  logic       ReqValid;
  logic [2:0] ReqSel;
  logic       ReqReady;
  logic [7:0] AckIn;
  logic [2:0] Sel;
  logic       Enable;
  logic       Busy;
  logic       Done;
  logic       Error;

  modport master (
    output ReqValid, ReqSel, AckIn,
    input  ReqReady, Sel, Enable, Busy, Done, Error
  );

  modport slave (
    input  ReqValid, ReqSel, AckIn,
    output ReqReady, Sel, Enable, Busy, Done, Error
  );
endinterface

// File: rtl/demux_strobe_sequencer.sv
// Single-target strobe sequencer driving the 8-way demux Sel/Enable pair.
// Optional timeout and Error pulse: define DEMUX_SEQ_TIMEOUT_EN.
module demux_strobe_sequencer #(
  parameter int unsigned HOLD_CYCLES    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic Clock,
  input  logic nReset,
  demux_strobe_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STROBE = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  logic [1:0] state;
  logic [2:0] sel;
  logic [3:0] hold_cnt;
  logic       sticky;
  logic       ack;
  logic       acked;
  logic       to_hit;

  assign ack   = bus.AckIn[sel];
  assign acked = sticky | ack;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      sel      <= 3'd0;
      hold_cnt <= 4'd0;
      sticky   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.ReqValid) begin
            sel      <= bus.ReqSel;
            hold_cnt <= 4'd0;
            sticky   <= 1'b0;
            state    <= STROBE;
          end
        end
        STROBE: begin
          if (ack)
            sticky <= 1'b1;
          if (hold_cnt != 4'hF)
            hold_cnt <= hold_cnt + 4'd1;
          if (hold_cnt == HOLD_LAST)
            state <= WAIT;
        end
        WAIT: begin
          if (acked || to_hit)
            state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEMUX_SEQ_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] to_cnt;
  logic       err;

  // to_hit marks the last permitted WAIT cycle; ack still wins there
  assign to_hit = (to_cnt == TO_LAST);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      to_cnt <= 8'd0;
      err    <= 1'b0;
    end else if (state == IDLE) begin
      to_cnt <= 8'd0;
      err    <= 1'b0;
    end else if (state == WAIT && !acked) begin
      if (to_hit)
        err <= 1'b1;
      else if (to_cnt != 8'hFF)
        to_cnt <= to_cnt + 8'd1;
    end
  end

  assign bus.Error = (state == DONE) & err;
`else
  assign to_hit    = 1'b0;
  assign bus.Error = 1'b0;
`endif

  assign bus.ReqReady = (state == IDLE);
  assign bus.Busy     = (state != IDLE);
  assign bus.Enable   = (state == STROBE);
  assign bus.Done     = (state == DONE);
  assign bus.Sel      = sel;

endmodule

// File: tb/tb_demux_strobe_sequencer.sv
// Scoreboard bench for demux_strobe_sequencer: three instances with
// default, long-hold and short-timeout parameters share clock and reset.
module tb_demux_strobe_sequencer;

  typedef struct {
    int         lat;
    logic [2:0] sel;
    logic       err;
  } exp_t;

  logic Clock = 1'b0;
  logic nReset;
  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];

  logic       rv[3];
  logic [2:0] rs[3];
  logic [7:0] ack[3];
  logic       ready[3];
  logic       en[3];
  logic       busy[3];
  logic       done[3];
  logic       erro[3];
  logic [2:0] sel[3];

  demux_strobe_sequencer_if b0 ();
  demux_strobe_sequencer_if b1 ();
  demux_strobe_sequencer_if b2 ();

  assign b0.ReqValid = rv[0];
  assign b0.ReqSel   = rs[0];
  assign b0.AckIn    = ack[0];
  assign b1.ReqValid = rv[1];
  assign b1.ReqSel   = rs[1];
  assign b1.AckIn    = ack[1];
  assign b2.ReqValid = rv[2];
  assign b2.ReqSel   = rs[2];
  assign b2.AckIn    = ack[2];

  assign ready[0] = b0.ReqReady;
  assign en[0]    = b0.Enable;
  assign busy[0]  = b0.Busy;
  assign done[0]  = b0.Done;
  assign erro[0]  = b0.Error;
  assign sel[0]   = b0.Sel;
  assign ready[1] = b1.ReqReady;
  assign en[1]    = b1.Enable;
  assign busy[1]  = b1.Busy;
  assign done[1]  = b1.Done;
  assign erro[1]  = b1.Error;
  assign sel[1]   = b1.Sel;
  assign ready[2] = b2.ReqReady;
  assign en[2]    = b2.Enable;
  assign busy[2]  = b2.Busy;
  assign done[2]  = b2.Done;
  assign erro[2]  = b2.Error;
  assign sel[2]   = b2.Sel;

  demux_strobe_sequencer u0 (
    .Clock (Clock), .nReset (nReset), .bus (b0.slave));

  demux_strobe_sequencer #(.HOLD_CYCLES(4)) u1 (
    .Clock (Clock), .nReset (nReset), .bus (b1.slave));

  demux_strobe_sequencer #(.HOLD_CYCLES(1), .TIMEOUT_CYCLES(3)) u2 (
    .Clock (Clock), .nReset (nReset), .bus (b2.slave));

  always #5 Clock = ~Clock;

  // Drives one request; k counts cycles after the accepting edge.
  task automatic run_txn(
    input  int d, input logic [2:0] s,
    input  logic [7:0] ack_on, input logic [7:0] ack_off,
    input  int ack_from, input int ack_to, input int max_k,
    input  int hold,
    output int done_k, output logic err_o, output logic [2:0] sel_o,
    output int en_n, output bit en_bad, output bit rb_bad);
    int n;
    done_k = 0; err_o = 1'b0; sel_o = 3'd0;
    en_n = 0; en_bad = 1'b0; rb_bad = 1'b0;
    @(negedge Clock);
    rv[d] = 1'b1;
    rs[d] = s;
    n = 0;
    while (!ready[d] && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (!ready[d]) begin
      rv[d] = 1'b0;
      return;
    end
    @(posedge Clock);
    #1 rv[d] = 1'b0;
    for (int k = 1; k <= max_k; k++) begin
      ack[d] = (k >= ack_from && k <= ack_to) ? ack_on : ack_off;
      @(negedge Clock);
      if (en[d]) en_n++;
      if (en[d] !== (k <= hold)) en_bad = 1'b1;
      if (ready[d] && busy[d]) rb_bad = 1'b1;
      if (done[d]) begin
        done_k = k;
        err_o  = erro[d];
        sel_o  = sel[d];
        break;
      end
      @(posedge Clock);
      #1;
    end
    ack[d] = 8'h00;
  endtask

  task automatic pulse_reset;
    @(negedge Clock);
    nReset = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;
  endtask

  task automatic test_reset;
    #1 nReset = 1'b0;
    @(negedge Clock);
    for (int d = 0; d < 3; d++) begin
      tests++;
      if ({ready[d], en[d], busy[d], done[d], erro[d], sel[d]} !== 8'b1000_0000) begin
        fails++;
        $display("FAIL reset_outputs dut%0d: got %b want 10000000", d,
          {ready[d], en[d], busy[d], done[d], erro[d], sel[d]});
      end
    end
    @(negedge Clock);
    nReset = 1'b1;
  endtask

  task automatic test_basic;
    int dk, en_n; logic eo; logic [2:0] so; bit eb, rb; exp_t e;
    sbq.push_back('{lat: 3, sel: 3'd5, err: 1'b0});
    run_txn(0, 3'd5, 8'h20, 8'h00, 2, 2, 10, 1, dk, eo, so, en_n, eb, rb);
    tests++;
    if (en_n !== 1 || eb) begin
      fails++;
      $display("FAIL basic_enable: got %0d cycles (shape_bad=%0d) want 1", en_n, eb);
    end
    tests++;
    if (dk == 0) begin
      fails++;
      $display("FAIL basic_done: got no Done want Done at 3");
    end else begin
      e = sbq.pop_front();
      if (dk !== e.lat || so !== e.sel || eo !== e.err) begin
        fails++;
        $display("FAIL basic_done: got k=%0d sel=%0d err=%0d want k=%0d sel=%0d err=%0d",
          dk, so, eo, e.lat, e.sel, e.err);
      end
    end
  endtask

  task automatic test_hold;
    int dk, en_n; logic eo; logic [2:0] so; bit eb, rb; exp_t e;
    sbq.push_back('{lat: 6, sel: 3'd2, err: 1'b0});
    run_txn(1, 3'd2, 8'h04, 8'h00, 2, 2, 20, 4, dk, eo, so, en_n, eb, rb);
    tests++;
    if (en_n !== 4 || eb) begin
      fails++;
      $display("FAIL hold_enable: got %0d cycles (shape_bad=%0d) want 4", en_n, eb);
    end
    tests++;
    if (dk == 0) begin
      fails++;
      $display("FAIL hold_done: got no Done want Done at 6");
    end else begin
      e = sbq.pop_front();
      if (dk !== e.lat || so !== e.sel || eo !== e.err) begin
        fails++;
        $display("FAIL hold_done: got k=%0d sel=%0d err=%0d want k=%0d sel=%0d err=%0d",
          dk, so, eo, e.lat, e.sel, e.err);
      end
    end
  endtask

  task automatic test_wrong_ack;
    int dk, en_n; logic eo; logic [2:0] so; bit eb, rb;
`ifdef DEMUX_SEQ_TIMEOUT_EN
    exp_t e;
    sbq.push_back('{lat: 17, sel: 3'd1, err: 1'b1});
    run_txn(0, 3'd1, 8'hFD, 8'hFD, 1, 100, 40, 1, dk, eo, so, en_n, eb, rb);
    tests++;
    if (dk == 0) begin
      fails++;
      $display("FAIL wrong_ack_timeout: got no Done want Done at 17");
    end else begin
      e = sbq.pop_front();
      if (dk !== e.lat || so !== e.sel || eo !== e.err) begin
        fails++;
        $display("FAIL wrong_ack_timeout: got k=%0d sel=%0d err=%0d want k=%0d sel=%0d err=%0d",
          dk, so, eo, e.lat, e.sel, e.err);
      end
    end
`else
    run_txn(0, 3'd1, 8'hFD, 8'hFD, 1, 100, 40, 1, dk, eo, so, en_n, eb, rb);
    tests++;
    if (dk !== 0 || busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL wrong_ack_hang: got done_k=%0d busy=%0d want 0 and 1", dk, busy[0]);
    end
    pulse_reset();
`endif
  endtask

  task automatic test_final_timeout;
    int dk, en_n; logic eo; logic [2:0] so; bit eb, rb; exp_t e;
    sbq.push_back('{lat: 5, sel: 3'd6, err: 1'b0});
    run_txn(2, 3'd6, 8'h40, 8'h00, 4, 4, 20, 1, dk, eo, so, en_n, eb, rb);
    tests++;
    if (dk == 0) begin
      fails++;
      $display("FAIL final_ack: got no Done want Done at 5");
    end else begin
      e = sbq.pop_front();
      if (dk !== e.lat || so !== e.sel || eo !== e.err) begin
        fails++;
        $display("FAIL final_ack: got k=%0d sel=%0d err=%0d want k=%0d sel=%0d err=%0d",
          dk, so, eo, e.lat, e.sel, e.err);
      end
    end
`ifdef DEMUX_SEQ_TIMEOUT_EN
    sbq.push_back('{lat: 5, sel: 3'd4, err: 1'b1});
    run_txn(2, 3'd4, 8'h00, 8'h00, 0, 0, 20, 1, dk, eo, so, en_n, eb, rb);
    tests++;
    if (dk == 0) begin
      fails++;
      $display("FAIL short_timeout: got no Done want Done at 5");
    end else begin
      e = sbq.pop_front();
      if (dk !== e.lat || so !== e.sel || eo !== e.err) begin
        fails++;
        $display("FAIL short_timeout: got k=%0d sel=%0d err=%0d want k=%0d sel=%0d err=%0d",
          dk, so, eo, e.lat, e.sel, e.err);
      end
    end
`endif
  endtask

  task automatic test_back_to_back;
    int dones, accs, last_done, c;
    bit rb_bad, toggle;
    logic en_prev;
    exp_t e;
    dones = 0; accs = 0; last_done = -1; c = 0;
    rb_bad = 1'b0; toggle = 1'b0; en_prev = 1'b0;
    ack[0] = 8'h81;
    @(negedge Clock);
    rv[0] = 1'b1;
    rs[0] = 3'd0;
    while (dones < 4 && c < 80) begin
      if (toggle) begin
        rs[0] = (rs[0] == 3'd0) ? 3'd7 : 3'd0;
        toggle = 1'b0;
      end
      if (ready[0] && busy[0]) rb_bad = 1'b1;
      if (en[0] && !en_prev && last_done >= 0) begin
        tests++;
        if (c - last_done !== 2) begin
          fails++;
          $display("FAIL b2b_gap: got %0d cycles Done->Enable want 2", c - last_done);
        end
      end
      if (done[0]) begin
        dones++;
        last_done = c;
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL b2b_done: got unexpected Done sel=%0d want none", sel[0]);
        end else begin
          e = sbq.pop_front();
          if (sel[0] !== e.sel || erro[0] !== e.err) begin
            fails++;
            $display("FAIL b2b_done: got sel=%0d err=%0d want sel=%0d err=%0d",
              sel[0], erro[0], e.sel, e.err);
          end
        end
        if (dones == 4) rv[0] = 1'b0;
      end
      if (ready[0] && rv[0]) begin
        accs++;
        sbq.push_back('{lat: 3, sel: rs[0], err: 1'b0});
        toggle = 1'b1;
      end
      en_prev = en[0];
      @(negedge Clock);
      c++;
    end
    ack[0] = 8'h00;
    tests++;
    if (dones !== 4 || accs !== 4 || rb_bad) begin
      fails++;
      $display("FAIL b2b_count: got dones=%0d accs=%0d ready_busy=%0d want 4 4 0",
        dones, accs, rb_bad);
    end
  endtask

  task automatic test_reset_abort;
    int dk, en_n, n; logic eo; logic [2:0] so; bit eb, rb, spurious; exp_t e;
    @(negedge Clock);
    rv[1] = 1'b1;
    rs[1] = 3'd6;
    n = 0;
    while (!ready[1] && n < 20) begin
      @(negedge Clock);
      n++;
    end
    @(posedge Clock);
    #1 rv[1] = 1'b0;
    @(negedge Clock);
    tests++;
    if (en[1] !== 1'b1) begin
      fails++;
      $display("FAIL abort_strobe: got Enable=%0d want 1", en[1]);
    end
    #1 nReset = 1'b0;
    #1;
    tests++;
    if (en[1] !== 1'b0 || busy[1] !== 1'b0) begin
      fails++;
      $display("FAIL abort_async: got Enable=%0d Busy=%0d want 0 0", en[1], busy[1]);
    end
    @(negedge Clock);
    nReset = 1'b1;
    spurious = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clock);
      if (done[1]) spurious = 1'b1;
    end
    tests++;
    if (spurious || ready[1] !== 1'b1) begin
      fails++;
      $display("FAIL abort_idle: got done_seen=%0d ReqReady=%0d want 0 1", spurious, ready[1]);
    end
    sbq.push_back('{lat: 6, sel: 3'd3, err: 1'b0});
    run_txn(1, 3'd3, 8'h08, 8'h00, 5, 5, 20, 4, dk, eo, so, en_n, eb, rb);
    tests++;
    if (dk == 0) begin
      fails++;
      $display("FAIL abort_recover: got no Done want Done at 6");
    end else begin
      e = sbq.pop_front();
      if (dk !== e.lat || so !== e.sel || eo !== e.err || eb || rb) begin
        fails++;
        $display("FAIL abort_recover: got k=%0d sel=%0d err=%0d want k=%0d sel=%0d err=%0d",
          dk, so, eo, e.lat, e.sel, e.err);
      end
    end
  endtask

  initial begin
    nReset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      rv[d]  = 1'b0;
      rs[d]  = 3'd0;
      ack[d] = 8'h00;
    end
    test_reset();
    test_basic();
    test_hold();
    test_wrong_ack();
    test_final_timeout();
    test_back_to_back();
    test_reset_abort();
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
